// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART_TX round-robin arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after i_Ptr, wrapping N_REQ-1 -> 0.
module uart_tx_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_Req,
    input  logic [ID_W-1:0]  i_Ptr,
    output logic [ID_W-1:0]  o_Gnt_Id,
    output logic             o_Any
);

    logic [ID_W-1:0] w_idx;

    // Scan farthest-first so the nearest candidate after i_Ptr overwrites the rest.
    always_comb begin
        // NOTE: every output and temporary gets a default first, so no path can infer a latch.
        o_Gnt_Id = '0;
        o_Any    = 1'b0;
        w_idx    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            w_idx = ID_W'((int'(i_Ptr) + off) % N_REQ);
            if (i_Req[w_idx]) begin
                o_Gnt_Id = w_idx;
                o_Any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX between N_REQ valid/ready byte sources,
// with a per-requester lock so multi-byte messages stay contiguous.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int START_TIMEOUT = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_L,
    input  logic [N_REQ-1:0]         i_Req_Valid,
    input  logic [8*N_REQ-1:0]       i_Req_Byte,
    input  logic [N_REQ-1:0]         i_Req_Lock,
    output logic [N_REQ-1:0]         o_Req_Ready,
    output logic                     o_TX_DV,
    output logic [7:0]               o_TX_Byte,
    input  logic                     i_TX_Active,
    input  logic                     i_TX_Done,
    output logic [$clog2(N_REQ)-1:0] o_Grant_Id,
    output logic                     o_Busy,
    output logic                     o_Err_Pulse
);

    import uart_tx_arbiter_pkg::*;

    localparam int ID_W    = $clog2(N_REQ);
    localparam int IDLE_W  = cnt_width(LOCK_TIMEOUT);
    localparam int START_W = cnt_width(START_TIMEOUT);
    localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(LOCK_TIMEOUT);
    localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT - 1);

    arb_state_t          r_state, w_next_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [7:0]          r_byte;
    logic                r_lock;
    logic                r_dv;
    logic                r_err;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [START_W-1:0]  r_start_cnt;

    logic [ID_W-1:0]     w_rr_id;
    logic                w_rr_any;
    logic                w_owner_valid;
    logic                w_accept;
    logic [ID_W-1:0]     w_accept_id;
    logic                w_stall;
    logic                w_lock_release;
    logic                w_start_abort;
    logic [7:0]          w_sel_byte;
    logic                w_sel_lock;
    logic [N_REQ-1:0]    w_ready;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_Req    (i_Req_Valid),
        .i_Ptr    (r_ptr),
        .o_Gnt_Id (w_rr_id),
        .o_Any    (w_rr_any)
    );

    assign w_owner_valid = r_lock & i_Req_Valid[r_grant_id];

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= ARB;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic so all registers update from pre-edge values.
            r_state <= w_next_state;
        end
    end

    // An owner that is valid always wins, even in the cycle its idle timeout expires.
    always_comb begin
        w_next_state   = r_state;
        w_accept       = 1'b0;
        w_accept_id    = r_grant_id;
        w_stall        = 1'b0;
        w_lock_release = 1'b0;
        w_start_abort  = 1'b0;
        case (r_state)
            ARB: begin
                if (w_owner_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end else if (r_lock && (r_idle_cnt != IDLE_MAX)) begin
                    w_stall = 1'b1;
                end else begin
                    w_lock_release = r_lock;
                    if (w_rr_any) begin
                        w_accept     = 1'b1;
                        w_accept_id  = w_rr_id;
                        w_next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_TX_Active) begin
                    w_next_state = WAIT_DONE;
                end else if (r_start_cnt == START_LAST) begin
                    w_start_abort = 1'b1;
                    w_next_state  = ARB;
                end
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    w_next_state = GAP;
                end
            end
            GAP: begin
                w_next_state = ARB;
            end
            default: begin
                w_next_state = ARB;
            end
        endcase
    end

    always_comb begin
        w_sel_byte = '0;
        w_sel_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_accept_id == ID_W'(i)) begin
                w_sel_byte = i_Req_Byte[8*i +: 8];
                w_sel_lock = i_Req_Lock[i];
            end
        end
    end

    // Ready is a combinational accept; gating with reset keeps it low while reset is held.
    always_comb begin
        w_ready = '0;
        if (w_accept && i_Rst_L) begin
            w_ready[w_accept_id] = 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_ptr       <= ID_W'(N_REQ - 1);
            r_grant_id  <= '0;
            r_byte      <= '0;
            r_lock      <= 1'b0;
            r_dv        <= 1'b0;
            r_err       <= 1'b0;
            r_idle_cnt  <= '0;
            r_start_cnt <= '0;
        end else begin
            r_err <= w_start_abort;
            if (w_stall) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_lock_release) begin
                r_lock     <= 1'b0;
                r_idle_cnt <= '0;
            end
            if (w_accept) begin
                r_byte      <= w_sel_byte;
                r_lock      <= w_sel_lock;
                r_grant_id  <= w_accept_id;
                r_ptr       <= w_accept_id;
                r_idle_cnt  <= '0;
                r_start_cnt <= '0;
                r_dv        <= 1'b1;
            end
            if (r_state == ISSUE) begin
                if (i_TX_Active || w_start_abort) begin
                    r_dv <= 1'b0;
                end else begin
                    r_start_cnt <= r_start_cnt + 1'b1;
                end
                if (w_start_abort) begin
                    r_lock <= 1'b0;
                end
            end
        end
    end

    assign o_Req_Ready = w_ready;
    assign o_TX_DV     = r_dv;
    assign o_TX_Byte   = r_byte;
    assign o_Grant_Id  = r_grant_id;
    assign o_Busy      = (r_state != ARB);
    assign o_Err_Pulse = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART_TX (4 clocks/bit), serial decoder and
// per-requester byte sources; expected {id,byte} and serial bytes are queued as stimulus is driven.
module tb_uart_tx_arbiter;

    localparam int N_REQ    = 4;
    localparam int CPB      = 4;
    localparam int LOCK_TO  = 8;
    localparam int START_TO = 16;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_byte;
    logic [N_REQ-1:0]   req_lock;
    logic [N_REQ-1:0]   ready;
    logic               tx_dv;
    logic [7:0]         tx_byte;
    logic               tx_active;
    logic               tx_done;
    logic [1:0]         grant_id;
    logic               busy;
    logic               err;
    logic               tx_serial;
    logic               tx_stuck;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_dv_q[$];
    logic [7:0] exp_rx_q[$];
    logic [8:0] src_q[N_REQ][$];

    uart_tx_arbiter #(
        .N_REQ         (N_REQ),
        .LOCK_TIMEOUT  (LOCK_TO),
        .START_TIMEOUT (START_TO)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Lock  (req_lock),
        .o_Req_Ready (ready),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done),
        .o_Grant_Id  (grant_id),
        .o_Busy      (busy),
        .o_Err_Pulse (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // UART_TX model; reads the arbiter's byte live each bit, so an unstable o_TX_Byte corrupts the frame.
    typedef enum logic [2:0] {M_IDLE, M_START, M_DATA, M_STOP, M_CLEANUP} m_state_t;
    m_state_t   m_state;
    logic [2:0] m_idx;
    int         m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state   <= M_IDLE;
            m_idx     <= '0;
            m_cnt     <= 0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    tx_serial <= 1'b1;
                    tx_done   <= 1'b0;
                    m_cnt     <= 0;
                    m_idx     <= '0;
                    if (tx_dv && !tx_stuck) begin
                        tx_active <= 1'b1;
                        m_state   <= M_START;
                    end
                end
                M_START: begin
                    tx_serial <= 1'b0;
                    if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                    else begin m_cnt <= 0; m_state <= M_DATA; end
                end
                M_DATA: begin
                    tx_serial <= tx_byte[m_idx];
                    if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                    else begin
                        m_cnt <= 0;
                        if (m_idx < 3'd7) m_idx <= m_idx + 3'd1;
                        else begin m_idx <= '0; m_state <= M_STOP; end
                    end
                end
                M_STOP: begin
                    tx_serial <= 1'b1;
                    if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                    else begin
                        m_cnt     <= 0;
                        tx_done   <= 1'b1;
                        tx_active <= 1'b0;
                        m_state   <= M_CLEANUP;
                    end
                end
                default: begin
                    tx_done <= 1'b1;
                    m_state <= M_IDLE;
                end
            endcase
        end
    end

    // Byte sources: pop on valid & ready, then present the next queued entry.
    initial begin
        logic [N_REQ-1:0] taken;
        req_valid = '0;
        req_byte  = '0;
        req_lock  = '0;
        forever begin
            @(negedge clk);
            taken = ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (taken[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_byte[8*i +: 8] = src_q[i][0][7:0];
                    req_lock[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_byte[8*i +: 8] = 8'h00;
                    req_lock[i]        = 1'b0;
                end
            end
        end
    end

    // Scoreboard at the arbiter output: each DV rising edge is one issued byte.
    initial begin
        logic       dv_prev;
        logic [9:0] exp_e;
        dv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dv_prev = 1'b0;
            end else begin
                if (tx_dv && !dv_prev) begin
                    total++;
                    if (exp_dv_q.size() == 0) begin
                        bad++;
                        $display("FAIL dv_issue: unexpected id=%0d byte=%02h, none required", grant_id, tx_byte);
                    end else begin
                        exp_e = exp_dv_q.pop_front();
                        if ({grant_id, tx_byte} !== exp_e) begin
                            bad++;
                            $display("FAIL dv_issue: got id=%0d byte=%02h, required id=%0d byte=%02h",
                                     grant_id, tx_byte, exp_e[9:8], exp_e[7:0]);
                        end
                    end
                end
                dv_prev = tx_dv;
            end
        end
    end

    // Serial decoder: start detected at negedge n0, data sampled at n6, n10, ... n34, stop at n38.
    initial begin
        logic       rx_busy;
        int         rx_cnt;
        logic [7:0] rx_shift;
        logic [7:0] exp_b;
        rx_busy  = 1'b0;
        rx_cnt   = 0;
        rx_shift = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (tx_serial === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 2 && tx_serial !== 1'b0) begin
                    rx_busy = 1'b0;
                end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) begin
                    rx_shift = {tx_serial, rx_shift[7:1]};
                end else if (rx_cnt == 38) begin
                    rx_busy = 1'b0;
                    total++;
                    if (exp_rx_q.size() == 0) begin
                        bad++;
                        $display("FAIL serial_rx: unexpected byte %02h, none required", rx_shift);
                    end else begin
                        exp_b = exp_rx_q.pop_front();
                        if (rx_shift !== exp_b || tx_serial !== 1'b1) begin
                            bad++;
                            $display("FAIL serial_rx: got %02h stop=%b, required %02h stop=1",
                                     rx_shift, tx_serial, exp_b);
                        end
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_dv_q.size() == 0 && exp_rx_q.size() == 0 && !busy &&
                src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && src_q[3].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n    = 1'b0;
        tx_stuck = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (tx_dv !== 1'b0)    begin bad++; $display("FAIL reset_dv: got %b, required 0", tx_dv); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        total++; if (ready !== 4'b0)    begin bad++; $display("FAIL reset_ready: got %b, required 0000", ready); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        total++; if (err !== 1'b0 || tx_byte !== 8'h00) begin
            bad++; $display("FAIL reset_err_byte: got err=%b byte=%02h, required 0/00", err, tx_byte);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain(10, ok);
        total++; if (!ok || tx_dv !== 1'b0 || ready !== 4'b0) begin
            bad++; $display("FAIL reset_idle: got ok=%b dv=%b ready=%b, required 1/0/0000", ok, tx_dv, ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        int k;
        apply_reset();
        exp_dv_q.push_back({2'd0, 8'h55});
        exp_rx_q.push_back(8'h55);
        src_q[0].push_back({1'b0, 8'h55});
        k = 0;
        do begin @(negedge clk); k++; end while (ready == 4'b0 && k < 50);
        total++; if (ready !== 4'b0001 || tx_dv !== 1'b0) begin
            bad++; $display("FAIL single_ready: got ready=%b dv=%b, required 0001/0", ready, tx_dv);
        end
        @(negedge clk);
        total++; if (ready !== 4'b0000 || tx_dv !== 1'b1 || tx_byte !== 8'h55) begin
            bad++; $display("FAIL single_dv: got ready=%b dv=%b byte=%02h, required 0000/1/55", ready, tx_dv, tx_byte);
        end
        k = 0;
        while (tx_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL single_done: got no Done, required Done within 100 cycles"); end
        k = 0;
        while (busy && k < 10) begin @(negedge clk); k++; end
        total++; if (k != 2) begin bad++; $display("FAIL single_busy_drop: got %0d cycles after Done, required 2", k); end
        wait_drain(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_drain: got pending items, required all delivered"); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [7:0] b;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N_REQ; i++) begin
                b = 8'hA0 + 8'(i);
                exp_dv_q.push_back({2'(i), b});
                exp_rx_q.push_back(b);
                src_q[i].push_back({1'b0, b});
            end
        end
        wait_drain(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_drain: got %0d/%0d pending, required 0", exp_dv_q.size(), exp_rx_q.size()); end
    endtask

    task automatic test_lock();
        bit ok;
        int k;
        apply_reset();
        src_q[2].push_back({1'b1, 8'h10});
        src_q[2].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b0, 8'h12});
        exp_dv_q.push_back({2'd2, 8'h10}); exp_dv_q.push_back({2'd2, 8'h11});
        exp_dv_q.push_back({2'd2, 8'h12}); exp_dv_q.push_back({2'd3, 8'h23});
        exp_dv_q.push_back({2'd0, 8'h20}); exp_dv_q.push_back({2'd1, 8'h21});
        exp_rx_q.push_back(8'h10); exp_rx_q.push_back(8'h11); exp_rx_q.push_back(8'h12);
        exp_rx_q.push_back(8'h23); exp_rx_q.push_back(8'h20); exp_rx_q.push_back(8'h21);
        k = 0;
        do begin @(negedge clk); k++; end while (ready == 4'b0 && k < 50);
        total++; if (ready !== 4'b0100) begin bad++; $display("FAIL lock_first: got ready=%b, required 0100", ready); end
        src_q[0].push_back({1'b0, 8'h20});
        src_q[1].push_back({1'b0, 8'h21});
        src_q[3].push_back({1'b0, 8'h23});
        wait_drain(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_drain: got %0d pending, required 0", exp_dv_q.size()); end
    endtask

    task automatic test_lock_timeout();
        bit ok;
        int k;
        apply_reset();
        src_q[1].push_back({1'b1, 8'h40});
        exp_dv_q.push_back({2'd1, 8'h40}); exp_dv_q.push_back({2'd3, 8'h43}); exp_dv_q.push_back({2'd0, 8'h44});
        exp_rx_q.push_back(8'h40); exp_rx_q.push_back(8'h43); exp_rx_q.push_back(8'h44);
        k = 0;
        do begin @(negedge clk); k++; end while (ready == 4'b0 && k < 50);
        src_q[3].push_back({1'b0, 8'h43});
        src_q[0].push_back({1'b0, 8'h44});
        k = 0;
        do begin @(negedge clk); k++; end while (!busy && k < 10);
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        k = 0;
        while (ready == 4'b0 && k < 40) begin @(negedge clk); k++; end
        total++; if (k != LOCK_TO || ready !== 4'b1000) begin
            bad++; $display("FAIL lock_timeout: got ready=%b after %0d idle cycles, required 1000 after %0d", ready, k, LOCK_TO);
        end
        wait_drain(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_timeout_drain: got %0d pending, required 0", exp_dv_q.size()); end
    endtask

    task automatic test_start_timeout();
        bit ok;
        int k;
        tx_stuck = 1'b1;
        apply_reset();
        src_q[0].push_back({1'b0, 8'h77});
        src_q[1].push_back({1'b0, 8'h78});
        exp_dv_q.push_back({2'd0, 8'h77}); exp_dv_q.push_back({2'd1, 8'h78});
        exp_rx_q.push_back(8'h78);
        k = 0;
        while (!tx_dv && k < 50) begin @(negedge clk); k++; end
        k = 0;
        while (tx_dv && k < 40) begin k++; @(negedge clk); end
        total++; if (k != START_TO) begin bad++; $display("FAIL start_dv_len: got %0d cycles, required %0d", k, START_TO); end
        total++; if (err !== 1'b1 || busy !== 1'b0 || tx_dv !== 1'b0) begin
            bad++; $display("FAIL start_abort: got err=%b busy=%b dv=%b, required 1/0/0", err, busy, tx_dv);
        end
        tx_stuck = 1'b0;
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL start_err_width: got err=%b, required 0", err); end
        wait_drain(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL start_drain: got %0d pending, required 0", exp_rx_q.size()); end
    endtask

    task automatic test_reset_mid_byte();
        bit ok;
        int k;
        apply_reset();
        src_q[0].push_back({1'b0, 8'hFF});
        src_q[0].push_back({1'b0, 8'h3C});
        exp_dv_q.push_back({2'd0, 8'hFF}); exp_dv_q.push_back({2'd0, 8'h3C});
        exp_rx_q.push_back(8'h3C);
        k = 0;
        while (!tx_dv && k < 50) begin @(negedge clk); k++; end
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({tx_dv, busy, ready, grant_id, err, tx_byte} !== 16'h0000) begin
            bad++; $display("FAIL midrst_outputs: got dv=%b busy=%b ready=%b id=%0d err=%b byte=%02h, required all 0",
                            tx_dv, busy, ready, grant_id, err, tx_byte);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_drain: got %0d pending, required 0", exp_rx_q.size()); end
    endtask

    initial begin
        tx_stuck = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_lock_timeout();
        test_start_timeout();
        test_reset_mid_byte();
        total++;
        if (exp_dv_q.size() != 0 || exp_rx_q.size() != 0) begin
            bad++; $display("FAIL leftover: got %0d dv / %0d rx expected items pending, required 0", exp_dv_q.size(), exp_rx_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
